// File: rtl/jt49_eg_sched.sv
// jt49_eg_sched: envelope register decode, prescaler/period timing and restart control.
// Optional macro JT49_EG_YM_RATE_EN selects the YM2149 doubled (32-step) envelope rate.
module jt49_eg_sched #(
    parameter int PRESCALE = 16,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic       step,
    output logic       null_period,
    output logic       restart,
    output logic [3:0] ctrl,
    output logic       running
);

    typedef enum logic [1:0] {IDLE, RESTART, RUN} state_t;

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
`ifdef JT49_EG_YM_RATE_EN
    localparam int TOP = PRESCALE / 2 - 1;
`else
    localparam int TOP = PRESCALE - 1;
`endif
    localparam logic [PW-1:0] PRE_TOP = PW'(TOP);

    state_t           state;
    state_t           phase;
    logic             pending;
    logic [PW-1:0]    pre_cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] per_cnt;
    logic [15:0]      per16;
    logic             wr13;
    logic             tick;
    logic             expire;

    assign per16       = 16'(period);
    assign wr13        = wr && (addr == 4'd13);
    assign tick        = (pre_cnt == PRE_TOP);
    assign expire      = ({1'b0, per_cnt} + (CNT_W+1)'(1)) >= {1'b0, period};
    assign null_period = running && (period == '0);

    // A pending shape write pre-empts whatever the FSM would do this cen.
    always_comb begin
        phase = state;
        if (pending) phase = RESTART;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period  <= '0;
            ctrl    <= '0;
            restart <= 1'b0;
        end else begin
            restart <= wr13;
            if (wr) begin
                unique case (addr)
                    4'd11: period <= CNT_W'({per16[15:8], din});
                    4'd12: period <= CNT_W'({din, per16[7:0]});
                    4'd13: ctrl   <= din[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            pre_cnt <= '0;
            per_cnt <= '0;
            step    <= 1'b0;
            running <= 1'b0;
        end else begin
            if (cen) begin
                unique case (phase)
                    IDLE: begin
                        pre_cnt <= '0;
                        per_cnt <= '0;
                        step    <= 1'b0;
                    end
                    RESTART: begin
                        pre_cnt <= '0;
                        per_cnt <= '0;
                        step    <= 1'b0;
                        pending <= 1'b0;
                        running <= 1'b1;
                        state   <= RUN;
                    end
                    RUN: begin
                        step    <= 1'b0;
                        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                        if (period == '0) begin
                            per_cnt <= '0;
                        end else if (tick) begin
                            if (expire) begin
                                per_cnt <= '0;
                                step    <= 1'b1;
                            end else begin
                                per_cnt <= per_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // A write landing on the RESTART cen re-arms a second restart.
            if (wr13) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jt49_eg_sched.sv
// tb_jt49_eg_sched: randomized and directed checks against a count-based envelope timing model.
module tb_jt49_eg_sched;

    localparam int PRE = 16;
`ifdef JT49_EG_YM_RATE_EN
    localparam int PRE_EFF = PRE / 2;
`else
    localparam int PRE_EFF = PRE;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] addr = 4'd0;
    logic [7:0] din = 8'd0;
    logic       step;
    logic       null_period;
    logic       restart;
    logic [3:0] ctrl;
    logic       running;

    int checks = 0;
    int errors = 0;

    jt49_eg_sched #(.PRESCALE(PRE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .addr(addr), .din(din),
        .step(step), .null_period(null_period), .restart(restart),
        .ctrl(ctrl), .running(running)
    );

    always #5 clk = ~clk;

    // Model: counts enabled cycles since restart; every PRE_EFF of them is a tick,
    // and a step fires when the ticks since the last step reach the period.
    int       m_period;
    logic [3:0] m_ctrl;
    bit       m_running, m_pend, m_restart, m_step, m_inrun;
    int       m_runcens, m_ticks, cen_idx;

    task automatic model_reset();
        m_period = 0; m_ctrl = 4'd0; m_running = 0; m_pend = 0;
        m_restart = 0; m_step = 0; m_inrun = 0; m_runcens = 0;
        m_ticks = 0; cen_idx = -1;
    endtask

    task automatic model_edge();
        int op;
        op = m_period;
        if (cen) begin
            if (cen_idx >= 0) cen_idx++;
            m_step = 0;
            if (m_pend) begin
                m_pend = 0; m_running = 1; m_inrun = 1;
                m_runcens = 0; m_ticks = 0;
            end else if (m_inrun) begin
                m_runcens++;
                if (op == 0) m_ticks = 0;
                else if (m_runcens % PRE_EFF == 0) begin
                    m_ticks++;
                    if (m_ticks >= op) begin
                        m_step = 1;
                        m_ticks = 0;
                    end
                end
            end
        end
        m_restart = 0;
        if (wr) begin
            case (addr)
                4'd11: m_period = (m_period & 32'hff00) | int'(din);
                4'd12: m_period = (m_period & 32'h00ff) | (int'(din) << 8);
                4'd13: begin
                    m_ctrl = din[3:0]; m_pend = 1; m_restart = 1; cen_idx = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic clk_cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; din = d;
        clk_cyc();
        wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b0; wr = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({step, restart, null_period, running, ctrl} !== 8'd0) begin
            errors++;
            $display("FAIL reset_values got %b want 00000000",
                     {step, restart, null_period, running, ctrl});
        end
        rst_n = 1'b1;
        cen = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            clk_cyc();
            checks++;
            if ({step, null_period, running, ctrl} !== 7'd0) begin
                errors++;
                $display("FAIL idle_quiet cyc %0d got %b want 0000000", i,
                         {step, null_period, running, ctrl});
            end
        end
    endtask

    task automatic test_basic();
        int first, second;
        first = -1; second = -1;
        cen = 1'b1;
        write_reg(4'd11, 8'h03);
        write_reg(4'd12, 8'h00);
        write_reg(4'd13, 8'h0E);
        checks++;
        if (restart !== 1'b1 || ctrl !== 4'hE) begin
            errors++;
            $display("FAIL basic_write restart=%b ctrl=%h want 1 e", restart, ctrl);
        end
        clk_cyc();
        checks++;
        if (restart !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL basic_restart restart=%b running=%b want 0 1", restart, running);
        end
        for (int i = 0; i < 8 * PRE_EFF; i++) begin
            clk_cyc();
            checks++;
            if (step !== m_step) begin
                errors++;
                $display("FAIL basic_step cen %0d got %b want %b", cen_idx, step, m_step);
            end
            if (step === 1'b1) begin
                if (first < 0) first = cen_idx;
                else if (second < 0) second = cen_idx;
            end
        end
        checks++;
        if (first != PRE_EFF * 3 + 1) begin
            errors++;
            $display("FAIL basic_first_step got cen %0d want %0d", first, PRE_EFF * 3 + 1);
        end
        checks++;
        if (second - first != PRE_EFF * 3) begin
            errors++;
            $display("FAIL basic_step_gap got %0d want %0d", second - first, PRE_EFF * 3);
        end
    endtask

    task automatic test_mid_period();
        int n, t1, t2, guard;
        n = 0; t1 = -1; t2 = -1; guard = 0;
        while (!(m_ticks == 2 && m_step == 0) && guard < 10 * PRE_EFF) begin
            clk_cyc();
            guard++;
        end
        checks++;
        if (guard >= 10 * PRE_EFF) begin
            errors++;
            $display("FAIL mid_wait timeout got %0d want <%0d", guard, 10 * PRE_EFF);
        end
        write_reg(4'd11, 8'h01);
        for (int i = 0; i < 4 * PRE_EFF; i++) begin
            clk_cyc();
            n++;
            checks++;
            if (step !== m_step) begin
                errors++;
                $display("FAIL mid_step n %0d got %b want %b", n, step, m_step);
            end
            if (step === 1'b1) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
        end
        checks++;
        if (t1 < 1 || t1 > PRE_EFF) begin
            errors++;
            $display("FAIL mid_first got %0d want 1..%0d", t1, PRE_EFF);
        end
        checks++;
        if (t2 - t1 != PRE_EFF) begin
            errors++;
            $display("FAIL mid_gap got %0d want %0d", t2 - t1, PRE_EFF);
        end
    endtask

    task automatic test_null();
        cen = 1'b1;
        write_reg(4'd11, 8'h00);
        write_reg(4'd12, 8'h00);
        write_reg(4'd13, 8'h08);
        clk_cyc();
        for (int i = 0; i < 200; i++) begin
            checks++;
            if (null_period !== 1'b1 || step !== 1'b0 || ctrl !== 4'h8) begin
                errors++;
                $display("FAIL null_run cyc %0d null=%b step=%b ctrl=%h want 1 0 8",
                         i, null_period, step, ctrl);
            end
            clk_cyc();
        end
    endtask

    task automatic test_coincide();
        int guard, got, want, first;
        guard = 0; got = 0; want = 0; first = -1;
        cen = 1'b1;
        write_reg(4'd11, 8'h02);
        write_reg(4'd13, 8'h0A);
        while (m_step == 0 && guard < 8 * PRE_EFF) begin
            clk_cyc();
            guard++;
        end
        write_reg(4'd13, 8'h0A);
        for (int i = 0; i < 6 * PRE_EFF; i++) begin
            clk_cyc();
            got += int'(step);
            want += int'(m_step);
            if (step === 1'b1 && first < 0) first = cen_idx;
        end
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL coincide_count got %0d want %0d", got, want);
        end
        checks++;
        if (first != PRE_EFF * 2 + 1) begin
            errors++;
            $display("FAIL coincide_first got cen %0d want %0d", first, PRE_EFF * 2 + 1);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 3000; i++) begin
            cen = ($urandom % 3) != 0;
            wr = ($urandom % 16) == 0;
            sel = int'($urandom % 4);
            addr = (sel == 3) ? 4'($urandom % 16) : 4'(11 + sel);
            din = (addr == 4'd12) ? (($urandom % 8 == 0) ? 8'd1 : 8'd0)
                                  : 8'($urandom_range(0, 3));
            clk_cyc();
            checks++;
            if (step !== m_step || restart !== m_restart || ctrl !== m_ctrl ||
                running !== m_running ||
                null_period !== (m_running && m_period == 0)) begin
                errors++;
                $display("FAIL random cyc %0d got s%b r%b n%b c%h u%b want s%b r%b n%b c%h u%b",
                         i, step, restart, null_period, ctrl, running,
                         m_step, m_restart, (m_running && m_period == 0), m_ctrl, m_running);
            end
        end
        wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        cen = 1'b1;
        write_reg(4'd11, 8'h01);
        write_reg(4'd12, 8'h00);
        write_reg(4'd13, 8'h0E);
        while (m_step == 0 && guard < 4 * PRE_EFF) begin
            clk_cyc();
            guard++;
        end
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_pulse got %b want 1", step);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (step !== 1'b0 || running !== 1'b0 || restart !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_async step=%b running=%b restart=%b want 0 0 0",
                     step, running, restart);
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_period();
        test_null();
        test_coincide();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
